// File: rtl/data_mem_ctrl_pkg.sv
// Shared definitions for the data-memory responder: defaults, queue-entry layout,
// access-size encoding and the per-byte forwarding lookup.
package data_mem_ctrl_pkg;

   localparam int MEM_AW_DEF   = 16;
   localparam int WQ_DEPTH_DEF = 4;

   // Queue entry layout, LSB first: data[15:0], size, addr[MEM_AW-1:0]
   localparam int ENT_DATA_LSB = 0;
   localparam int ENT_SIZE_BIT = 16;
   localparam int ENT_ADDR_LSB = 17;

   typedef enum logic {
      SIZE_BYTE = 1'b0,
      SIZE_WORD = 1'b1
   } size_e;

   // Returns {hit, byte}: does a write of the given size at w_addr cover byte t_addr?
   function automatic logic [8:0] fwd_lookup(input logic [31:0] w_addr,
                                             input size_e       w_size,
                                             input logic [15:0] w_data,
                                             input logic [31:0] t_addr,
                                             input logic [31:0] amask);
      logic [8:0] r;
      r = 9'h000;
      if ((w_addr & amask) == (t_addr & amask))
         r = {1'b1, w_data[7:0]};
      else if ((w_size == SIZE_WORD) && (((w_addr + 32'd1) & amask) == (t_addr & amask)))
         r = {1'b1, w_data[15:8]};
      return r;
   endfunction

endpackage

// File: rtl/data_mem_ctrl_wq_fifo.sv
// Circular posted-write FIFO. Besides the head it exposes every entry in
// program order (index 0 = head) with a valid vector, for read forwarding.
module data_mem_ctrl_wq_fifo
   import data_mem_ctrl_pkg::*;
#(
   parameter  int W     = 33,
   parameter  int DEPTH = WQ_DEPTH_DEF,
   localparam int PW    = $clog2(DEPTH),
   localparam int CW    = $clog2(DEPTH + 1)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 push,
   input  logic                 pop,
   input  logic [W-1:0]         push_data,
   output logic [CW-1:0]        count,
   output logic [DEPTH-1:0]     valid,
   output logic [DEPTH*W-1:0]   entries
);

   logic [W-1:0]  slot_q [DEPTH];
   logic [W-1:0]  slot_d [DEPTH];
   logic [PW-1:0] head_q, head_d, tail_q, tail_d;
   logic [CW-1:0] count_q, count_d;
   logic [PW:0]   slot_idx;

   function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
   endfunction

   always_comb begin
      slot_d  = slot_q;
      head_d  = head_q;
      tail_d  = tail_q;
      count_d = count_q + CW'(push) - CW'(pop);
      if (push) begin
         slot_d[tail_q] = push_data;
         tail_d         = next_ptr(tail_q);
      end
      if (pop)
         head_d = next_ptr(head_q);
   end

   // Rotate physical slots into program order; DEPTH need not be a power of two
   always_comb begin
      entries  = '0;
      valid    = '0;
      slot_idx = '0;
      for (int i = 0; i < DEPTH; i++) begin
         slot_idx = {1'b0, head_q} + (PW + 1)'(i);
         if (slot_idx >= (PW + 1)'(DEPTH))
            slot_idx = slot_idx - (PW + 1)'(DEPTH);
         entries[i*W +: W] = slot_q[slot_idx[PW-1:0]];
         valid[i]          = CW'(i) < count_q;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
      end else begin
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
      end
   end

   always_ff @(posedge clk) begin
      slot_q <= slot_d;
   end

   assign count = count_q;

endmodule

// File: rtl/data_mem_ctrl.sv
// Data-memory responder: even/odd byte banks, posted write queue drained in
// read-idle cycles, and per-byte forwarding so reads observe program order.
module data_mem_ctrl
   import data_mem_ctrl_pkg::*;
#(
   parameter int MEM_AW   = MEM_AW_DEF,
   parameter int WQ_DEPTH = WQ_DEPTH_DEF
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        ram_rd_en,
   input  logic        ram_rd_we,
   input  logic [19:0] ram_rd_addr,
   output logic [15:0] ram_rd_data,
   output logic        rd_valid,
   input  logic        ram_wr_en,
   input  logic        ram_wr_we,
   input  logic [19:0] ram_wr_addr,
   input  logic [15:0] ram_wr_data,
   output logic        busy,
   output logic        wq_ovf
);

   localparam int          EW    = MEM_AW + ENT_ADDR_LSB;
   localparam int          RW    = MEM_AW - 1;
   localparam int          CW    = $clog2(WQ_DEPTH + 1);
   localparam logic [31:0] AMASK = 32'((64'd1 << MEM_AW) - 64'd1);

   logic [MEM_AW-1:0]     rd_a, wr_a, head_a;
   logic [RW-1:0]         rd_row, even_rrow, head_row, even_wrow;
   logic [CW-1:0]         wq_count, count_d;
   logic [WQ_DEPTH-1:0]   wq_valid;
   logic [WQ_DEPTH*EW-1:0] wq_entries;
   logic [EW-1:0]         wr_entry, head_entry;
   logic                  drain, enq, head_word, even_we, odd_we;
   logic [7:0]            even_wdata, odd_wdata;
   logic [7:0]            even_bank_q [2**RW];
   logic [7:0]            odd_bank_q  [2**RW];
   logic [7:0]            even_rd_q, odd_rd_q;
   logic [31:0]           fwd_addr;
   logic [8:0]            fwd_hit;
   logic [1:0]            fwd_mask_d, fwd_mask_q;
   logic [1:0][7:0]       fwd_byte_d, fwd_byte_q;
   logic                  rd_valid_d, rd_valid_q, rd_word_d, rd_word_q, rd_odd_d, rd_odd_q;
   logic                  busy_d, busy_q, wq_ovf_d, wq_ovf_q;
   logic [7:0]            lo_byte, hi_byte;
   logic [15:0]           merged, rd_hold_d, rd_hold_q;
   logic                  unused_hi_addr;

   assign rd_a           = ram_rd_addr[MEM_AW-1:0];
   assign wr_a           = ram_wr_addr[MEM_AW-1:0];
   assign unused_hi_addr = ^{ram_rd_addr[19:MEM_AW], ram_wr_addr[19:MEM_AW]};

   // Reads own both bank ports, so the queue only drains when no read is requested
   assign drain      = rst && !ram_rd_en && (wq_count != '0);
   assign enq        = rst && ram_wr_en && ((wq_count != CW'(WQ_DEPTH)) || drain);
   assign wr_entry   = {wr_a, ram_wr_we, ram_wr_data};
   assign head_entry = wq_entries[EW-1:0];

   data_mem_ctrl_wq_fifo #(
      .W     (EW),
      .DEPTH (WQ_DEPTH)
   ) u_wq (
      .clk       (clk),
      .rst       (rst),
      .push      (enq),
      .pop       (drain),
      .push_data (wr_entry),
      .count     (wq_count),
      .valid     (wq_valid),
      .entries   (wq_entries)
   );

   // An odd-aligned word spans odd row r and even row r+1 (wrapping at the top)
   always_comb begin
      head_a     = head_entry[ENT_ADDR_LSB +: MEM_AW];
      head_word  = size_e'(head_entry[ENT_SIZE_BIT]) == SIZE_WORD;
      head_row   = head_a[MEM_AW-1:1];
      even_we    = drain && (head_word || !head_a[0]);
      odd_we     = drain && (head_word || head_a[0]);
      even_wrow  = head_a[0] ? head_row + RW'(1) : head_row;
      even_wdata = head_a[0] ? head_entry[ENT_DATA_LSB + 8 +: 8] : head_entry[ENT_DATA_LSB +: 8];
      odd_wdata  = head_a[0] ? head_entry[ENT_DATA_LSB +: 8] : head_entry[ENT_DATA_LSB + 8 +: 8];
      rd_row     = rd_a[MEM_AW-1:1];
      even_rrow  = rd_a[0] ? rd_row + RW'(1) : rd_row;
   end

   always_ff @(posedge clk) begin
      if (even_we)
         even_bank_q[even_wrow] <= even_wdata;
      if (odd_we)
         odd_bank_q[head_row] <= odd_wdata;
      if (ram_rd_en) begin
         even_rd_q <= even_bank_q[even_rrow];
         odd_rd_q  <= odd_bank_q[rd_row];
      end
   end

   // Later matches override earlier ones: head..tail, then the same-cycle write
   always_comb begin
      fwd_mask_d = '0;
      fwd_byte_d = '0;
      fwd_addr   = '0;
      fwd_hit    = '0;
      for (int k = 0; k < 2; k++) begin
         fwd_addr = 32'(rd_a) + 32'(k);
         for (int i = 0; i < WQ_DEPTH; i++) begin
            if (wq_valid[i]) begin
               fwd_hit = fwd_lookup(32'(wq_entries[i*EW + ENT_ADDR_LSB +: MEM_AW]),
                                    size_e'(wq_entries[i*EW + ENT_SIZE_BIT]),
                                    wq_entries[i*EW + ENT_DATA_LSB +: 16], fwd_addr, AMASK);
               if (fwd_hit[8]) begin
                  fwd_mask_d[k] = 1'b1;
                  fwd_byte_d[k] = fwd_hit[7:0];
               end
            end
         end
         if (enq) begin
            fwd_hit = fwd_lookup(32'(wr_a), size_e'(ram_wr_we), ram_wr_data, fwd_addr, AMASK);
            if (fwd_hit[8]) begin
               fwd_mask_d[k] = 1'b1;
               fwd_byte_d[k] = fwd_hit[7:0];
            end
         end
      end
   end

   always_comb begin
      rd_valid_d = ram_rd_en;
      rd_word_d  = ram_rd_we;
      rd_odd_d   = rd_a[0];
      lo_byte    = fwd_mask_q[0] ? fwd_byte_q[0] : (rd_odd_q ? odd_rd_q : even_rd_q);
      hi_byte    = fwd_mask_q[1] ? fwd_byte_q[1] : (rd_odd_q ? even_rd_q : odd_rd_q);
      merged     = rd_word_q ? {hi_byte, lo_byte} : {8'h00, lo_byte};
      rd_hold_d  = rd_valid_q ? merged : rd_hold_q;
      count_d    = wq_count + CW'(enq) - CW'(drain);
      busy_d     = count_d >= CW'(WQ_DEPTH - 1);
      wq_ovf_d   = wq_ovf_q || (ram_wr_en && !enq);
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         rd_valid_q <= 1'b0;
         rd_hold_q  <= '0;
         busy_q     <= 1'b0;
         wq_ovf_q   <= 1'b0;
         rd_word_q  <= 1'b0;
         rd_odd_q   <= 1'b0;
         fwd_mask_q <= '0;
         fwd_byte_q <= '0;
      end else begin
         rd_valid_q <= rd_valid_d;
         rd_hold_q  <= rd_hold_d;
         busy_q     <= busy_d;
         wq_ovf_q   <= wq_ovf_d;
         rd_word_q  <= rd_word_d;
         rd_odd_q   <= rd_odd_d;
         fwd_mask_q <= fwd_mask_d;
         fwd_byte_q <= fwd_byte_d;
      end
   end

   assign ram_rd_data = rd_hold_d;
   assign rd_valid    = rd_valid_q;
   assign busy        = busy_q;
   assign wq_ovf      = wq_ovf_q;

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Bench for data_mem_ctrl: program-order memory model compared every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_data_mem_ctrl;

   localparam int DEPTH = 4;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        ramRdEn = 1'b0, ramRdWe = 1'b0, ramWrEn = 1'b0, ramWrWe = 1'b0;
   logic [19:0] ramRdAddr = '0, ramWrAddr = '0;
   logic [15:0] ramWrData = '0;
   logic [15:0] ramRdData;
   logic        rdValid, busy, wqOvf;

   int checks = 0;
   int errors = 0;

   typedef struct {
      bit [15:0] a;
      bit        word;
      bit [15:0] d;
   } wr_t;

   // archMem: what a program-order reader sees; bankMem: what has actually retired
   bit [7:0]  archMem [65536];
   bit [7:0]  bankMem [65536];
   wr_t       pending [$];
   bit        mLive = 0;
   bit        mValid = 0, mBusy = 0, mOvf = 0;
   bit [15:0] mData = '0;

   data_mem_ctrl dut (
      .clk         (clk),
      .rst         (rst),
      .ram_rd_en   (ramRdEn),
      .ram_rd_we   (ramRdWe),
      .ram_rd_addr (ramRdAddr),
      .ram_rd_data (ramRdData),
      .rd_valid    (rdValid),
      .ram_wr_en   (ramWrEn),
      .ram_wr_we   (ramWrWe),
      .ram_wr_addr (ramWrAddr),
      .ram_wr_data (ramWrData),
      .busy        (busy),
      .wq_ovf      (wqOvf)
   );

   always #5 clk = ~clk;

   task automatic check16(input string name, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic void writeMem(input bit toBank, input wr_t w);
      if (toBank) begin
         bankMem[w.a] = w.d[7:0];
         if (w.word) bankMem[w.a + 16'd1] = w.d[15:8];
      end else begin
         archMem[w.a] = w.d[7:0];
         if (w.word) archMem[w.a + 16'd1] = w.d[15:8];
      end
   endfunction

   // Reference model: the queue only decides timing and acceptance; data comes from archMem
   always @(posedge clk) begin
      bit  drainNow, acceptNow;
      wr_t w;
      if (!rst) begin
         pending.delete();
         archMem = bankMem;
         mValid  = 0;
         mData   = '0;
         mBusy   = 0;
         mOvf    = 0;
         mLive   = 1;
      end else if (mLive) begin
         drainNow  = !ramRdEn && (pending.size() > 0);
         acceptNow = ramWrEn && ((pending.size() < DEPTH) || drainNow);
         if (drainNow) writeMem(1'b1, pending.pop_front());
         if (acceptNow) begin
            w.a = ramWrAddr[15:0]; w.word = ramWrWe; w.d = ramWrData;
            writeMem(1'b0, w);
            pending.push_back(w);
         end
         if (ramWrEn && !acceptNow) mOvf = 1;
         mValid = ramRdEn;
         if (ramRdEn)
            mData = ramRdWe ? {archMem[ramRdAddr[15:0] + 16'd1], archMem[ramRdAddr[15:0]]}
                            : {8'h00, archMem[ramRdAddr[15:0]]};
         mBusy = pending.size() >= DEPTH - 1;
      end
   end

   task automatic checkOutput();
      check16("rd_valid", 16'(rdValid), 16'(mValid));
      check16("ram_rd_data", ramRdData, mData);
      check16("busy", 16'(busy), 16'(mBusy));
      check16("wq_ovf", 16'(wqOvf), 16'(mOvf));
   endtask

   always @(negedge clk) if (mLive) checkOutput();

   // Drive one cycle of requests; returns #1 after the sampling edge
   task automatic applyStimulus(input logic rdEn, input logic rdWe, input logic [19:0] rdAddr,
                                input logic wrEn, input logic wrWe, input logic [19:0] wrAddr,
                                input logic [15:0] wrData);
      ramRdEn = rdEn; ramRdWe = rdWe; ramRdAddr = rdAddr;
      ramWrEn = wrEn; ramWrWe = wrWe; ramWrAddr = wrAddr; ramWrData = wrData;
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) applyStimulus(0, 0, '0, 0, 0, '0, '0);
   endtask

   task automatic readByte(input logic [19:0] a);
      applyStimulus(1, 0, a, 0, 0, '0, '0);
   endtask

   task automatic readWord(input logic [19:0] a);
      applyStimulus(1, 1, a, 0, 0, '0, '0);
   endtask

   function automatic logic [19:0] pickAddr();
      logic [15:0] lo;
      lo = ($urandom_range(0, 1) == 0) ? 16'($urandom_range(0, 63))
                                       : 16'hFFC0 + 16'($urandom_range(0, 63));
      return {4'($urandom_range(0, 15)), lo};
   endfunction

   initial begin
      #1_000_000;
      $display("[TB] FAIL watchdog: simulation did not complete");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      logic [15:0] initList [$];
      bit rdR, wrR;

      rst = 0;
      idle(2);
      check16("reset rd_valid", 16'(rdValid), 16'h0000);
      check16("reset data", ramRdData, 16'h0000);
      check16("reset busy", 16'(busy), 16'h0000);
      check16("reset wq_ovf", 16'(wqOvf), 16'h0000);
      rst = 1;

      for (int a = 0; a <= 16'h40; a++) initList.push_back(16'(a));
      for (int a = 16'hFFC0; a <= 16'hFFFF; a++) initList.push_back(16'(a));
      initList.push_back(16'h0123);
      for (int a = 16'h0200; a <= 16'h0203; a++) initList.push_back(16'(a));
      for (int a = 16'h0300; a <= 16'h0303; a++) initList.push_back(16'(a));
      foreach (initList[i])
         applyStimulus(0, 0, '0, 1, 0, {4'h0, initList[i]}, 16'($urandom));
      idle(3);

      $display("[TB] byte write then read back from banks");
      applyStimulus(0, 0, '0, 1, 0, 20'h00123, 16'h00AB);
      idle(2);
      readByte(20'h00123);
      check16("t1 rd_valid", 16'(rdValid), 16'h0001);
      check16("t1 data", ramRdData, 16'h00AB);

      $display("[TB] misaligned word forwarded from queue, then from banks");
      applyStimulus(0, 0, '0, 1, 1, 20'h00201, 16'hBEEF);
      readWord(20'h00201);
      check16("t2 fwd", ramRdData, 16'hBEEF);
      idle(3);
      readWord(20'h00201);
      check16("t2 bank", ramRdData, 16'hBEEF);

      $display("[TB] same-cycle write forwards one overlapping byte");
      applyStimulus(1, 0, 20'h00301, 1, 1, 20'h00300, 16'h1234);
      check16("t3 partial", ramRdData, 16'h0012);
      readByte(20'h00302);
      idle(4);

      $display("[TB] word write wraps at top of address space");
      applyStimulus(0, 0, '0, 1, 1, 20'h0FFFF, 16'hA55A);
      idle(3);
      readByte(20'h00000);
      check16("t4 wrap hi", ramRdData, 16'h00A5);
      readByte(20'h0FFFF);
      check16("t4 top lo", ramRdData, 16'h005A);
      readByte(20'h1FFFF);
      check16("t4 alias", ramRdData, 16'h005A);
      readWord(20'h0FFFF);
      check16("t4 word wrap", ramRdData, 16'hA55A);

      $display("[TB] queue fills under continuous reads");
      for (int i = 0; i < DEPTH + 1; i++) begin
         applyStimulus(1, 0, 20'h00010, 1, 1, 20'h00020 + 20'(2 * i), 16'($urandom));
         if (i == 1) check16("t5 busy at 2", 16'(busy), 16'h0000);
         if (i == 2) check16("t5 busy at 3", 16'(busy), 16'h0001);
      end
      check16("t5 overflow", 16'(wqOvf), 16'h0001);
      idle(1);
      check16("t5 drain to 3", 16'(busy), 16'h0001);
      idle(1);
      check16("t5 drain to 2", 16'(busy), 16'h0000);
      idle(3);

      $display("[TB] reset discards queued writes");
      applyStimulus(1, 0, 20'h00010, 1, 0, 20'h00123, 16'h00CD);
      applyStimulus(1, 0, 20'h00010, 1, 1, 20'h00201, 16'h1111);
      applyStimulus(1, 0, 20'h00010, 1, 0, 20'h00000, 16'h0077);
      rst = 0;
      readByte(20'h00010);
      check16("t6 rd_valid", 16'(rdValid), 16'h0000);
      check16("t6 data", ramRdData, 16'h0000);
      check16("t6 busy", 16'(busy), 16'h0000);
      check16("t6 wq_ovf", 16'(wqOvf), 16'h0000);
      rst = 1;
      idle(2);
      readByte(20'h00123);
      check16("t6 old byte", ramRdData, 16'h00AB);
      readWord(20'h00201);
      check16("t6 old word", ramRdData, 16'hBEEF);
      readByte(20'h00000);
      check16("t6 old wrap", ramRdData, 16'h00A5);

      $display("[TB] randomized traffic");
      for (int c = 0; c < 4000; c++) begin
         rdR = $urandom_range(0, 99) < 55;
         wrR = $urandom_range(0, 99) < 45 && (!busy || $urandom_range(0, 19) == 0);
         rst = ($urandom_range(0, 499) == 0) ? 1'b0 : 1'b1;
         applyStimulus(rdR, 1'($urandom_range(0, 1)), pickAddr(),
                       wrR, 1'($urandom_range(0, 1)), pickAddr(), 16'($urandom));
      end
      rst = 1;
      idle(8);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
